// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
// Holds the default frame geometry, the parity-type constants and the
// receiver state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_OVERSAMPLE = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: two-flop synchronizer, per-bit oversample counter,
// three-point capture around mid-bit and majority vote. The vote is valid
// while the counter sits at OS/2+2; the bit ends at OS-1.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  input  logic i_clr,
  output logic o_rx_s,
  output logic o_bit,
  output logic o_sample_valid,
  output logic o_bit_end
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_S2   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_EVAL = CW'(OVERSAMPLE / 2 + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  logic          r_sync1;
  logic          r_rx_s;
  logic [CW-1:0] r_edge_cnt;
  logic          r_s0, r_s1, r_s2;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_rx_s  <= r_sync1;
    end
  end

  // Position within the current bit period; realigned on a start edge.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_edge_cnt <= '0;
    end else if (r_edge_cnt == CNT_LAST) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= r_edge_cnt + 1'b1;
    end
  end

  // Capture the three points straddling the bit centre.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      if (r_edge_cnt == CNT_S0) r_s0 <= r_rx_s;
      if (r_edge_cnt == CNT_S1) r_s1 <= r_rx_s;
      if (r_edge_cnt == CNT_S2) r_s2 <= r_rx_s;
    end
  end

  assign o_rx_s         = r_rx_s;
  assign o_bit          = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
  assign o_sample_valid = (r_edge_cnt == CNT_EVAL);
  assign o_bit_end      = (r_edge_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (start, DATA_WIDTH data bits LSB
// first, optional parity, one stop bit). Each frame ends with a one-cycle
// data_valid, parity_error and/or stop_error pulse.
// Build option: define UART_RX_PARITY_EN to include the parity state and
// checker; otherwise PAR_EN/PAR_TYP are ignored and parity_error is 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  rx_state_e r_state, w_next;

  logic w_rx_s, w_bit, w_sample_valid, w_bit_end;
  logic w_start, w_shift, w_frame_end;

  logic                  r_armed;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_stop_error;

`ifdef UART_RX_PARITY_EN
  logic r_par_en, r_par_typ, r_par_err, r_parity_error;
  logic w_par_chk, w_par_exp;
`else
  logic w_unused_par;
  assign w_unused_par = PAR_EN ^ PAR_TYP;
`endif

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .i_rx          (rx_in),
    .i_clr         (w_start),
    .o_rx_s        (w_rx_s),
    .o_bit         (w_bit),
    .o_sample_valid(w_sample_valid),
    .o_bit_end     (w_bit_end)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RX_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; STOP leaves at mid-bit so a back-to-back start is seen.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (r_armed && !w_rx_s) w_next = RX_START;
      RX_START: begin
        if (w_sample_valid && w_bit) w_next = RX_IDLE;
        else if (w_bit_end)          w_next = RX_DATA;
      end
      RX_DATA: begin
        if (w_bit_end && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          w_next = r_par_en ? RX_PARITY : RX_STOP;
`else
          w_next = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: if (w_bit_end) w_next = RX_STOP;
`endif
      RX_STOP:  if (w_sample_valid) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    w_start     = (r_state == RX_IDLE) && r_armed && !w_rx_s;
    w_shift     = (r_state == RX_DATA) && w_sample_valid;
    w_frame_end = (r_state == RX_STOP) && w_sample_valid;
`ifdef UART_RX_PARITY_EN
    w_par_chk   = (r_state == RX_PARITY) && w_sample_valid;
`endif
  end

`ifdef UART_RX_PARITY_EN
  assign w_par_exp = (r_par_typ == PAR_ODD) ? ~^r_shift : ^r_shift;
`endif

  // Datapath: arming, bit count, shift register, parity check, output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed      <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_stop_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_en       <= 1'b0;
      r_par_typ      <= 1'b0;
      r_par_err      <= 1'b0;
      r_parity_error <= 1'b0;
`endif
    end else begin
      r_data_valid <= 1'b0;
      r_stop_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_error <= 1'b0;
`endif
      // A low stop bit disarms until the line is seen high again (break).
      if (w_frame_end && !w_bit) r_armed <= 1'b0;
      else if (w_rx_s)           r_armed <= 1'b1;

      if (w_start) begin
        r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
        r_par_err <= 1'b0;
`endif
      end else if ((r_state == RX_DATA) && w_bit_end) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_shift) r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};

`ifdef UART_RX_PARITY_EN
      if (w_par_chk) r_par_err <= (w_bit != w_par_exp);
`endif

      if (w_frame_end) begin
        r_data_out   <= r_shift;
        r_stop_error <= !w_bit;
`ifdef UART_RX_PARITY_EN
        r_parity_error <= r_par_err;
        r_data_valid   <= w_bit && !r_par_err;
`else
        r_data_valid   <= w_bit;
`endif
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign stop_error = r_stop_error;
`ifdef UART_RX_PARITY_EN
  assign parity_error = r_parity_error;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks every cycle
// against a frame-level model (queue of expected end-of-frame events).
module tb_uart_rx;

  localparam int unsigned DW = 8;
  localparam int unsigned OS = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PBUILD = 1'b1;
`else
  localparam bit PBUILD = 1'b0;
`endif

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    bit          pe;
    bit          se;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid, parity_error, stop_error;

  uart_rx #(
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_error(parity_error),
    .stop_error  (stop_error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic        rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  int vectors = 0;
  int miscompares = 0;

  exp_t        q[$];
  int unsigned vcyc[$];
  int          n_valid = 0, n_perr = 0, n_serr = 0;
  int unsigned last_pulse_cyc = 0;
  int unsigned last_T = 0;
  logic [7:0]  last_data = '0;
  exp_t        e_cur;
  bit          e_v, e_pe, e_se;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the frame-level model.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      e_v = 1'b0; e_pe = 1'b0; e_se = 1'b0;
      if (rst_q) begin
        last_data = '0;
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          chk("pulse_missed", cyc, q[0].cyc);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e_cur = q.pop_front();
          e_pe = e_cur.pe;
          e_se = e_cur.se;
          e_v  = !e_cur.pe && !e_cur.se;
          last_data = e_cur.data;
        end
      end
      chk("data_valid", {31'd0, data_valid}, {31'd0, e_v});
      chk("parity_error", {31'd0, parity_error}, {31'd0, e_pe});
      chk("stop_error", {31'd0, stop_error}, {31'd0, e_se});
      chk("data_out", {24'd0, data_out}, {24'd0, last_data});
      if (data_valid === 1'b1) begin n_valid++; vcyc.push_back(cyc); end
      if (parity_error === 1'b1) n_perr++;
      if (stop_error === 1'b1) n_serr++;
      if (data_valid === 1'b1 || parity_error === 1'b1 || stop_error === 1'b1)
        last_pulse_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    tick(n);
  endtask

  // Drive one frame; abort_bit >= 0 asserts rst midway through that bit.
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt,
                            input bit flip, input bit stop_v, input int abort_bit);
    bit   par_on;
    int   nb;
    logic bits[12];
    exp_t e;
    par_on = PBUILD && pe;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = d[i];
    nb = 1 + DW;
    if (par_on) begin
      bits[nb] = (($countones(d) % 2) == 1) ^ pt ^ flip;
      nb++;
    end
    bits[nb] = stop_v;
    nb++;
    PAR_EN  = pe;
    PAR_TYP = pt;
    last_T  = cyc + 2;
    if (abort_bit < 0) begin
      e.cyc  = last_T + OS * (nb - 1) + OS / 2 + 4;
      e.data = d;
      e.pe   = par_on && flip;
      e.se   = !stop_v;
      q.push_back(e);
    end
    for (int i = 0; i < nb; i++) begin
      rx_in = bits[i];
      if (i == abort_bit) begin
        tick(OS / 2);
        rst   = 1'b1;
        rx_in = 1'b1;
        q.delete();
        tick(5);
        rst = 1'b0;
        tick(12);
        return;
      end
      if (i == 1) begin
        PAR_EN  = 1'($urandom_range(0, 1));
        PAR_TYP = 1'($urandom_range(0, 1));
      end
      tick(OS);
    end
  endtask

  int v0, p0, s0;
  bit prev_stop;
  int gap;

  initial begin
    tick(4);
    rst = 1'b0;
    chk("reset_data_out", {24'd0, data_out}, 32'h0);
    idle(10);

    // 0xA5, no parity
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(10);
    chk("a5_latency", last_pulse_cyc - last_T, 32'd80);
    chk("a5_data", {24'd0, data_out}, 32'hA5);

    // 0x3C with correct even parity
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle(10);
`ifdef UART_RX_PARITY_EN
    chk("3c_latency", last_pulse_cyc - last_T, 32'd88);
`else
    chk("3c_latency", last_pulse_cyc - last_T, 32'd80);
`endif
    chk("3c_data", {24'd0, data_out}, 32'h3C);

    // 0x3C with flipped parity bit
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    idle(10);
`ifdef UART_RX_PARITY_EN
    chk("3c_flip_perr", n_perr - p0, 32'd1);
    chk("3c_flip_valid", n_valid - v0, 32'd0);
`else
    chk("3c_flip_perr", n_perr - p0, 32'd0);
    chk("3c_flip_valid", n_valid - v0, 32'd1);
`endif
    chk("3c_flip_data", {24'd0, data_out}, 32'h3C);

    // 0x81 with low stop bit, then break held 40 cycles
    v0 = n_valid; s0 = n_serr;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    tick(40);
    idle(20);
    chk("break_serr", n_serr - s0, 32'd1);
    chk("break_valid", n_valid - v0, 32'd0);
    chk("break_data", {24'd0, data_out}, 32'h81);

    // 3-cycle glitch, then 0x55
    v0 = n_valid; s0 = n_serr;
    rx_in = 1'b0;
    tick(3);
    idle(30);
    chk("glitch_pulses", (n_valid - v0) + (n_serr - s0), 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(10);
    chk("55_data", {24'd0, data_out}, 32'h55);

    // Back-to-back 0x12, 0x34
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(10);
    chk("b2b_spacing", vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2], 32'd80);
    chk("b2b_data", {24'd0, data_out}, 32'h34);

    // Reset in 4th data bit, then 0xF0
    v0 = n_valid;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    chk("abort_data_out", {24'd0, data_out}, 32'h0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(10);
    chk("f0_data", {24'd0, data_out}, 32'hF0);
    chk("f0_valid_count", n_valid - v0, 32'd1);

    // Randomized frames
    prev_stop = 1'b1;
    for (int k = 0; k < 150; k++) begin
      bit sv;
      sv = ($urandom_range(0, 9) != 0);
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), sv, -1);
      gap = $urandom_range(0, 15);
      if (!sv && gap < 2) gap = 2;
      idle(gap);
      prev_stop = sv;
    end
    idle(100);
    chk("queue_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side counterpart of the UART transmitter. Recovers frames of one start bit, DATA_WIDTH data bits (LSB first), an optional parity bit and one stop bit from the serial line. Each bit is majority-voted from three oversampled points, and each frame is reported with a one-cycle valid or error pulse. Sits between the pad-side serial input and the byte consumer, clocked by the same oversample clock that drives the transmitter.

## Interface
- DATA_WIDTH, 8, data bits per frame
- OVERSAMPLE, 8, clk cycles per bit period; even, ≥ 8
- clk  input  1  oversample clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_in  input  1  asynchronous serial line; idle high
- PAR_EN  input  1  1 = frame carries a parity bit
- PAR_TYP  input  1  0 = even, 1 = odd parity
- data_out  output  DATA_WIDTH  last received data word
- data_valid  output  1  one-cycle pulse: frame received with no error
- parity_error  output  1  one-cycle pulse: parity mismatch
- stop_error  output  1  one-cycle pulse: stop bit sampled low

## Operation
- rx_in passes through a 2-flop synchronizer (rx_s). Both flops reset to 1.
- edge_cnt counts 0..OVERSAMPLE-1 within each bit. Samples are taken at edge_cnt = OS/2-1, OS/2 and OS/2+1. The majority of the three is evaluated at edge_cnt = OS/2+2.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Start detection is armed only after rx_s has been seen high since reset or since the last stop_error.
  - When armed and rx_s = 0: go to START with edge_cnt = 0, and latch PAR_EN/PAR_TYP for the whole frame.
- START: at evaluation, a majority of 1 is a glitch: return to IDLE with no pulse. Otherwise go to DATA at edge_cnt = OS-1.
- DATA: at each evaluation, shift the voted bit into the shift register, LSB first. After bit DATA_WIDTH-1, at edge_cnt = OS-1, go to PARITY if the latched PAR_EN is 1, otherwise go to STOP.
- PARITY: at evaluation, compare the voted bit against the expected value. Expected is ^data for even parity and ~^data for odd parity. Record a mismatch. Go to STOP at edge_cnt = OS-1.
- STOP, at evaluation:
  - Load data_out from the shift register (always, even when an error is flagged).
  - Pulse stop_error if the voted bit is 0.
  - Pulse parity_error if a mismatch was recorded.
  - Pulse data_valid only if neither error occurred.
  - Go directly to IDLE, mid stop bit, so a back-to-back start edge is caught.
- Both error pulses may assert in the same cycle.
- Reset values: data_out = 0, data_valid = 0, parity_error = 0, stop_error = 0. State = IDLE, disarmed, counters = 0.
- rst mid-frame: abort immediately with no pulse. The next frame needs rx_s high, then a new low.
- Line held low (break): produces one frame with stop_error. No further frames until the line returns high.

## Timing
- T = the cycle in which IDLE sees armed and rx_s = 0. The synchronizer adds 2 cycles from rx_in to rx_s.
- edge_cnt = k of the start bit occurs in cycle T+1+k.
- The outputs pulse in cycle T + OS·(1+DATA_WIDTH+P) + OS/2 + 4, where P = 1 if parity is enabled, else 0.
  - OS=8, DW=8, no parity: T+80.
  - OS=8, DW=8, with parity: T+88.
- The pulses are registered and exactly one cycle wide. data_out is stable from the pulse cycle until the next frame end.
- Changing PAR_EN/PAR_TYP mid-frame has no effect on the current frame.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state and checker present; behaviour as above.
- UART_RX_PARITY_EN undefined:
  - No PARITY state and no parity logic.
  - PAR_EN and PAR_TYP are ignored, and every frame is start + data + stop.
  - parity_error is tied to 0.

## Structure
- Shared package uart_pkg holds:
  - the receiver state encoding localparams (IDLE, START, DATA, PARITY, STOP; 3 bits);
  - the parity-type constants (PAR_EVEN = 0, PAR_ODD = 1);
  - the default DATA_WIDTH and OVERSAMPLE values shared with the transmitter.
- One sub-module, uart_rx_sampler, contains the synchronizer, edge_cnt, the three-sample capture and the majority vote. It outputs the voted bit, a sample-valid strobe at OS/2+2, and a bit-end strobe at OS-1.
- FSM, shift register, parity checker and output registers live in uart_rx.

## Test plan
- Frame 0xA5, no parity, OS=8 → data_valid high for exactly cycle T+80; data_out = 0xA5; both error flags 0.
- Frame 0x3C with even parity bit 0 and PAR_TYP=0 → data_valid at T+88, data_out = 0x3C. Repeat with the parity bit flipped to 1 → parity_error pulse, data_valid stays 0, data_out = 0x3C.
- Frame 0x81 with stop bit driven 0 → stop_error pulse, data_valid 0. Then hold the line low for 40 cycles → no second frame until the line returns high.
- 3-cycle low glitch on an idle line → return to IDLE, no output pulse. Then a valid frame 0x55 → data_valid with 0x55.
- Two back-to-back frames 0x12 and 0x34, next start edge immediately after the stop bit → two data_valid pulses, exactly 80 cycles apart.
- Assert rst in the 4th data bit of a frame, release it, then send 0xF0 → no pulse for the aborted frame; outputs 0 during reset; 0xF0 received correctly.
